// File: rtl/solver_scheduler.sv
// solver_scheduler: hands Mandelbrot pixel jobs to a pool of solver instances,
// loading each job's limbs through a shared write port, starting the solver,
// and returning tagged iteration counts to the host over valid/ready.
module solver_scheduler #(
    parameter int NUM_SOLVERS     = 4,
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_SIZE_BITS  = 8,
    parameter int TAG_BITS        = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        job_valid,
    output logic                        job_ready,
    input  logic [TAG_BITS-1:0]         job_tag,
    input  logic [LIMB_INDEX_BITS-1:0]  job_num_limbs,
    input  logic [15:0]                 job_iter_lim,
    input  logic                        limb_valid,
    output logic                        limb_ready,
    input  logic [LIMB_SIZE_BITS-1:0]   limb_re,
    input  logic [LIMB_SIZE_BITS-1:0]   limb_im,
    output logic [NUM_SOLVERS-1:0]      sol_wr_en,
    output logic [LIMB_INDEX_BITS-1:0]  sol_wr_index,
    output logic [LIMB_SIZE_BITS-1:0]   sol_real_data,
    output logic [LIMB_SIZE_BITS-1:0]   sol_imag_data,
    output logic [LIMB_INDEX_BITS-1:0]  sol_num_limbs,
    output logic [15:0]                 sol_iter_lim,
    output logic [NUM_SOLVERS-1:0]      sol_start,
    input  logic [NUM_SOLVERS-1:0]      sol_out_ready,
    input  logic [16*NUM_SOLVERS-1:0]   sol_iterations,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [TAG_BITS-1:0]         res_tag,
    output logic [15:0]                 res_iterations,
    output logic [NUM_SOLVERS-1:0]      busy_mask
);

    localparam int SEL_BITS = (NUM_SOLVERS > 1) ? $clog2(NUM_SOLVERS) : 1;
    localparam logic [NUM_SOLVERS-1:0] ONE = 1;
    localparam logic [SEL_BITS-1:0] LAST_SEL = SEL_BITS'(NUM_SOLVERS - 1);

    typedef enum logic [1:0] {IDLE, LOAD, START} state_t;

    // Round-robin search: {found, index} of the first set bit at or after ptr.
    function automatic logic [SEL_BITS:0] pickFirst(input logic [NUM_SOLVERS-1:0] mask,
                                                     input logic [SEL_BITS-1:0] ptr);
        logic [SEL_BITS:0] result;
        int pos;
        result = '0;
        for (int k = NUM_SOLVERS - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % NUM_SOLVERS;
            if (mask[pos]) result = {1'b1, SEL_BITS'(pos)};
        end
        return result;
    endfunction

    function automatic logic [SEL_BITS-1:0] nextSel(input logic [SEL_BITS-1:0] i);
        return (i == LAST_SEL) ? '0 : i + 1'b1;
    endfunction

    state_t                      state_q, state_d;
    logic [SEL_BITS-1:0]         sel_q, sel_d;
    logic [LIMB_INDEX_BITS-1:0]  idx_q, idx_d;
    logic [TAG_BITS-1:0]         tag_q, tag_d;
    logic [LIMB_INDEX_BITS-1:0]  numLimbs_q, numLimbs_d;
    logic [15:0]                 iterLim_q, iterLim_d;
    logic [SEL_BITS-1:0]         dispPtr_q, dispPtr_d;
    logic [NUM_SOLVERS-1:0]      wrEn_q, wrEn_d;
    logic [LIMB_INDEX_BITS-1:0]  wrIndex_q, wrIndex_d;
    logic [LIMB_SIZE_BITS-1:0]   realData_q, realData_d;
    logic [LIMB_SIZE_BITS-1:0]   imagData_q, imagData_d;
    logic [LIMB_INDEX_BITS-1:0]  solNumLimbs_q, solNumLimbs_d;
    logic [15:0]                 solIterLim_q, solIterLim_d;

    logic [NUM_SOLVERS-1:0]      busy_q, busy_d;
    logic [NUM_SOLVERS-1:0]      start_q, start_d;
    logic [TAG_BITS-1:0]         tagR_q [NUM_SOLVERS];
    logic [TAG_BITS-1:0]         tagR_d [NUM_SOLVERS];
    logic [SEL_BITS-1:0]         resPtr_q, resPtr_d;
    logic [SEL_BITS-1:0]         rsel_q, rsel_d;
    logic                        resValid_q, resValid_d;
    logic [TAG_BITS-1:0]         resTag_q, resTag_d;
    logic [15:0]                 resIter_q, resIter_d;

    logic [SEL_BITS:0]           idlePick;
    logic [SEL_BITS:0]           resPick;
    logic [NUM_SOLVERS-1:0]      candidates;
    logic                        dispatchNow;
    logic                        popNow;
    logic                        captureNow;

    assign idlePick = pickFirst(~busy_q, dispPtr_q);

    // Dispatch FSM: accept a header into an idle solver, stream its limbs, then start it.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        idx_d         = idx_q;
        tag_d         = tag_q;
        numLimbs_d    = numLimbs_q;
        iterLim_d     = iterLim_q;
        dispPtr_d     = dispPtr_q;
        wrEn_d        = '0;
        wrIndex_d     = wrIndex_q;
        realData_d    = realData_q;
        imagData_d    = imagData_q;
        solNumLimbs_d = solNumLimbs_q;
        solIterLim_d  = solIterLim_q;
        job_ready     = 1'b0;
        limb_ready    = 1'b0;
        dispatchNow   = 1'b0;
        case (state_q)
            IDLE: begin
                job_ready = job_valid && idlePick[SEL_BITS];
                if (job_ready) begin
                    sel_d      = idlePick[SEL_BITS-1:0];
                    tag_d      = job_tag;
                    numLimbs_d = job_num_limbs;
                    iterLim_d  = job_iter_lim;
                    idx_d      = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                limb_ready = 1'b1;
                if (limb_valid) begin
                    wrEn_d        = ONE << sel_q;
                    wrIndex_d     = idx_q;
                    realData_d    = limb_re;
                    imagData_d    = limb_im;
                    solNumLimbs_d = numLimbs_q;
                    solIterLim_d  = iterLim_q;
                    idx_d         = idx_q + 1'b1;
                    if (idx_q == numLimbs_q) state_d = START;
                end
            end
            START: begin
                dispatchNow = 1'b1;
                dispPtr_d   = nextSel(sel_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Dispatch state and the registered solver write port.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            sel_q         <= '0;
            idx_q         <= '0;
            tag_q         <= '0;
            numLimbs_q    <= '0;
            iterLim_q     <= '0;
            dispPtr_q     <= '0;
            wrEn_q        <= '0;
            wrIndex_q     <= '0;
            realData_q    <= '0;
            imagData_q    <= '0;
            solNumLimbs_q <= '0;
            solIterLim_q  <= '0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            idx_q         <= idx_d;
            tag_q         <= tag_d;
            numLimbs_q    <= numLimbs_d;
            iterLim_q     <= iterLim_d;
            dispPtr_q     <= dispPtr_d;
            wrEn_q        <= wrEn_d;
            wrIndex_q     <= wrIndex_d;
            realData_q    <= realData_d;
            imagData_q    <= imagData_d;
            solNumLimbs_q <= solNumLimbs_d;
            solIterLim_q  <= solIterLim_d;
        end
    end

    // Result capture and pool bookkeeping; a popped solver is excluded from same-cycle capture.
    always_comb begin
        popNow     = resValid_q && res_ready;
        candidates = busy_q & sol_out_ready & ~wrEn_q;
        if (popNow) candidates = candidates & ~(ONE << rsel_q);
        resPick    = pickFirst(candidates, resPtr_q);
        captureNow = (!resValid_q || popNow) && resPick[SEL_BITS];
        resValid_d = resValid_q;
        resTag_d   = resTag_q;
        resIter_d  = resIter_q;
        rsel_d     = rsel_q;
        resPtr_d   = resPtr_q;
        busy_d     = busy_q;
        start_d    = start_q;
        tagR_d     = tagR_q;
        if (popNow) begin
            resValid_d     = 1'b0;
            busy_d[rsel_q]  = 1'b0;
            start_d[rsel_q] = 1'b0;
        end
        if (captureNow) begin
            resValid_d = 1'b1;
            resTag_d   = tagR_q[resPick[SEL_BITS-1:0]];
            resIter_d  = sol_iterations[16*int'(resPick[SEL_BITS-1:0]) +: 16];
            rsel_d     = resPick[SEL_BITS-1:0];
            resPtr_d   = nextSel(resPick[SEL_BITS-1:0]);
        end
        if (dispatchNow) begin
            busy_d[sel_q]  = 1'b1;
            start_d[sel_q] = 1'b1;
            tagR_d[sel_q]  = tag_q;
        end
    end

    // Pool occupancy, per-solver tags and the result register.
    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q     <= '0;
            start_q    <= '0;
            tagR_q     <= '{default: '0};
            resPtr_q   <= '0;
            rsel_q     <= '0;
            resValid_q <= 1'b0;
            resTag_q   <= '0;
            resIter_q  <= '0;
        end else begin
            busy_q     <= busy_d;
            start_q    <= start_d;
            tagR_q     <= tagR_d;
            resPtr_q   <= resPtr_d;
            rsel_q     <= rsel_d;
            resValid_q <= resValid_d;
            resTag_q   <= resTag_d;
            resIter_q  <= resIter_d;
        end
    end

    assign sol_wr_en      = wrEn_q;
    assign sol_wr_index   = wrIndex_q;
    assign sol_real_data  = realData_q;
    assign sol_imag_data  = imagData_q;
    assign sol_num_limbs  = solNumLimbs_q;
    assign sol_iter_lim   = solIterLim_q;
    assign sol_start      = start_q;
    assign res_valid      = resValid_q;
    assign res_tag        = resTag_q;
    assign res_iterations = resIter_q;
    assign busy_mask      = busy_q;

endmodule

// File: tb/tb_solver_scheduler.sv
// tb_solver_scheduler: directed bench for solver_scheduler; the bench plays the
// host and the four solvers, with hand-computed expectations at every step.
module tb_solver_scheduler;

    logic         clock;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [15:0]  job_tag;
    logic [5:0]   job_num_limbs;
    logic [15:0]  job_iter_lim;
    logic         limb_valid;
    logic         limb_ready;
    logic [7:0]   limb_re;
    logic [7:0]   limb_im;
    logic [3:0]   sol_wr_en;
    logic [5:0]   sol_wr_index;
    logic [7:0]   sol_real_data;
    logic [7:0]   sol_imag_data;
    logic [5:0]   sol_num_limbs;
    logic [15:0]  sol_iter_lim;
    logic [3:0]   sol_start;
    logic [3:0]   sol_out_ready;
    logic [63:0]  sol_iterations;
    logic         res_valid;
    logic         res_ready;
    logic [15:0]  res_tag;
    logic [15:0]  res_iterations;
    logic [3:0]   busy_mask;

    int compared;
    int mismatched;

    solver_scheduler #(
        .NUM_SOLVERS(4),
        .LIMB_INDEX_BITS(6),
        .LIMB_SIZE_BITS(8),
        .TAG_BITS(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_tag(job_tag),
        .job_num_limbs(job_num_limbs),
        .job_iter_lim(job_iter_lim),
        .limb_valid(limb_valid),
        .limb_ready(limb_ready),
        .limb_re(limb_re),
        .limb_im(limb_im),
        .sol_wr_en(sol_wr_en),
        .sol_wr_index(sol_wr_index),
        .sol_real_data(sol_real_data),
        .sol_imag_data(sol_imag_data),
        .sol_num_limbs(sol_num_limbs),
        .sol_iter_lim(sol_iter_lim),
        .sol_start(sol_start),
        .sol_out_ready(sol_out_ready),
        .sol_iterations(sol_iterations),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_tag(res_tag),
        .res_iterations(res_iterations),
        .busy_mask(busy_mask)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Hard time limit so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected summary before time limit");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_job_ready", 64'(job_ready), 64'd0);
        checkOutput("rst_limb_ready", 64'(limb_ready), 64'd0);
        checkOutput("rst_wr_en", 64'(sol_wr_en), 64'd0);
        checkOutput("rst_wr_index", 64'(sol_wr_index), 64'd0);
        checkOutput("rst_real", 64'(sol_real_data), 64'd0);
        checkOutput("rst_num_limbs", 64'(sol_num_limbs), 64'd0);
        checkOutput("rst_iter_lim", 64'(sol_iter_lim), 64'd0);
        checkOutput("rst_start", 64'(sol_start), 64'd0);
        checkOutput("rst_res_valid", 64'(res_valid), 64'd0);
        checkOutput("rst_res_tag", 64'(res_tag), 64'd0);
        checkOutput("rst_res_iter", 64'(res_iterations), 64'd0);
        checkOutput("rst_busy", 64'(busy_mask), 64'd0);
    endtask

    task automatic doReset(input int cycles);
        reset = 1'b1;
        job_valid = 1'b0;
        job_tag = '0;
        job_num_limbs = '0;
        job_iter_lim = '0;
        limb_valid = 1'b0;
        limb_re = '0;
        limb_im = '0;
        sol_out_ready = '0;
        sol_iterations = '0;
        res_ready = 1'b0;
        repeat (cycles) tick();
        checkResetState();
        reset = 1'b0;
    endtask

    // Streams numLimbs+1 beats (stallMask bit set = limb_valid low that cycle) and checks writes and start.
    task automatic loadLimbs(input logic [5:0] numLimbs, input logic [15:0] iterLim, input int expSel,
                             input logic [31:0] reBytes, input logic [31:0] imBytes, input logic [31:0] stallMask);
        int beat;
        int cyc;
        beat = 0;
        cyc = 0;
        while (beat <= int'(numLimbs) && cyc < 32) begin
            limb_valid = !stallMask[cyc];
            limb_re = limb_valid ? reBytes[8*beat +: 8] : 8'hEE;
            limb_im = limb_valid ? imBytes[8*beat +: 8] : 8'hEE;
            #1;
            checkOutput("limb_ready_load", 64'(limb_ready), 64'd1);
            checkOutput("job_ready_load", 64'(job_ready), 64'd0);
            tick();
            if (limb_valid) begin
                checkOutput("wr_en", 64'(sol_wr_en), 64'd1 << expSel);
                checkOutput("wr_index", 64'(sol_wr_index), 64'(beat));
                checkOutput("wr_real", 64'(sol_real_data), 64'(reBytes[8*beat +: 8]));
                checkOutput("wr_imag", 64'(sol_imag_data), 64'(imBytes[8*beat +: 8]));
                checkOutput("wr_num_limbs", 64'(sol_num_limbs), 64'(numLimbs));
                checkOutput("wr_iter_lim", 64'(sol_iter_lim), 64'(iterLim));
                beat++;
            end else begin
                checkOutput("wr_stalled", 64'(sol_wr_en), 64'd0);
            end
            cyc++;
        end
        checkOutput("load_bounded", 64'(cyc < 32), 64'd1);
        limb_valid = 1'b0;
        limb_re = '0;
        limb_im = '0;
        #1;
        checkOutput("limb_ready_start", 64'(limb_ready), 64'd0);
        checkOutput("start_pending", 64'(sol_start[expSel]), 64'd0);
        tick();
        checkOutput("start", 64'(sol_start[expSel]), 64'd1);
        checkOutput("busy_after_start", 64'(busy_mask[expSel]), 64'd1);
        checkOutput("wr_after_start", 64'(sol_wr_en), 64'd0);
    endtask

    // Presents one job header, expects it accepted this cycle, then loads its limbs.
    task automatic applyStimulus(input logic [15:0] tag, input logic [5:0] numLimbs, input logic [15:0] iterLim,
                                 input int expSel, input logic [31:0] reBytes, input logic [31:0] imBytes,
                                 input logic [31:0] stallMask);
        job_valid = 1'b1;
        job_tag = tag;
        job_num_limbs = numLimbs;
        job_iter_lim = iterLim;
        #1;
        checkOutput("job_ready", 64'(job_ready), 64'd1);
        checkOutput("limb_ready_idle", 64'(limb_ready), 64'd0);
        tick();
        job_valid = 1'b0;
        job_tag = '0;
        job_num_limbs = '0;
        job_iter_lim = '0;
        loadLimbs(numLimbs, iterLim, expSel, reBytes, imBytes, stallMask);
    endtask

    // Directed sequence.
    initial begin
        compared = 0;
        mismatched = 0;
        reset = 1'b1;
        doReset(2);

        $display("[TB] single job");
        applyStimulus(16'h0005, 6'd2, 16'd10, 0, 32'h0000_8000, 32'h0000_0000, 32'h0);
        sol_iterations[15:0] = 16'd10;
        sol_out_ready = 4'b0001;
        #1;
        checkOutput("res_valid_before", 64'(res_valid), 64'd0);
        tick();
        checkOutput("res_valid_single", 64'(res_valid), 64'd1);
        checkOutput("res_tag_single", 64'(res_tag), 64'h5);
        checkOutput("res_iter_single", 64'(res_iterations), 64'd10);
        res_ready = 1'b1;
        tick();
        checkOutput("res_valid_popped", 64'(res_valid), 64'd0);
        checkOutput("busy_popped", 64'(busy_mask), 64'h0);
        checkOutput("start_popped", 64'(sol_start), 64'h0);
        res_ready = 1'b0;
        sol_out_ready = 4'b0000;
        tick();
        checkOutput("res_valid_idle", 64'(res_valid), 64'd0);

        $display("[TB] fill pool and backpressure");
        doReset(2);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0011 + 16'(i), 6'd0, 16'(16'h0100 * (i + 1)), i,
                          32'hA1 + 32'(i), 32'hB1 + 32'(i), 32'h0);
        end
        checkOutput("busy_full", 64'(busy_mask), 64'hF);
        job_valid = 1'b1;
        job_tag = 16'h0015;
        job_num_limbs = 6'd0;
        job_iter_lim = 16'h0500;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("job_ready_full", 64'(job_ready), 64'd0);
            tick();
        end
        sol_iterations = {16'h0033, 16'h0000, 16'h0031, 16'h0000};
        sol_out_ready = 4'b1010;
        res_ready = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("hold_valid", 64'(res_valid), 64'd1);
            checkOutput("hold_tag", 64'(res_tag), 64'h12);
            checkOutput("hold_iter", 64'(res_iterations), 64'h31);
            checkOutput("hold_job_ready", 64'(job_ready), 64'd0);
            tick();
        end
        res_ready = 1'b1;
        #1;
        checkOutput("pre_pop_tag", 64'(res_tag), 64'h12);
        tick();
        checkOutput("second_valid", 64'(res_valid), 64'd1);
        checkOutput("second_tag", 64'(res_tag), 64'h14);
        checkOutput("second_iter", 64'(res_iterations), 64'h33);
        checkOutput("busy_one_freed", 64'(busy_mask), 64'hD);
        checkOutput("job_ready_freed", 64'(job_ready), 64'd1);
        tick();
        checkOutput("both_popped_valid", 64'(res_valid), 64'd0);
        checkOutput("busy_two_freed", 64'(busy_mask), 64'h5);
        checkOutput("fifth_in_load", 64'(limb_ready), 64'd1);
        res_ready = 1'b0;
        sol_out_ready = 4'b0000;
        job_valid = 1'b0;
        job_tag = '0;
        job_iter_lim = '0;
        loadLimbs(6'd0, 16'h0500, 1, 32'h0000_00A5, 32'h0000_00B5, 32'h0);
        checkOutput("busy_after_fifth", 64'(busy_mask), 64'h7);

        $display("[TB] limb stall");
        applyStimulus(16'h0016, 6'd2, 16'h0600, 3, 32'h0033_2211, 32'h0066_5544, 32'h0000_0006);
        checkOutput("busy_after_stall", 64'(busy_mask), 64'hF);

        $display("[TB] reset mid-load");
        sol_iterations = {16'h0000, 16'h0077, 16'h0000, 16'h0000};
        sol_out_ready = 4'b0100;
        tick();
        checkOutput("pop2_valid", 64'(res_valid), 64'd1);
        checkOutput("pop2_tag", 64'(res_tag), 64'h13);
        checkOutput("pop2_iter", 64'(res_iterations), 64'h77);
        res_ready = 1'b1;
        tick();
        checkOutput("pop2_done", 64'(res_valid), 64'd0);
        checkOutput("busy_pop2", 64'(busy_mask), 64'hB);
        res_ready = 1'b0;
        sol_out_ready = 4'b0000;
        job_valid = 1'b1;
        job_tag = 16'h0021;
        job_num_limbs = 6'd2;
        job_iter_lim = 16'h0700;
        #1;
        checkOutput("partial_job_ready", 64'(job_ready), 64'd1);
        tick();
        job_valid = 1'b0;
        limb_valid = 1'b1;
        limb_re = 8'h5A;
        limb_im = 8'hA5;
        tick();
        checkOutput("partial_wr_en", 64'(sol_wr_en), 64'h4);
        checkOutput("partial_wr_index", 64'(sol_wr_index), 64'd0);
        doReset(1);
        applyStimulus(16'h0022, 6'd1, 16'h0800, 0, 32'h0000_9281, 32'h0000_B4A3, 32'h0);
        sol_iterations = {48'h0, 16'h0088};
        sol_out_ready = 4'b0001;
        tick();
        checkOutput("after_reset_tag", 64'(res_tag), 64'h22);
        checkOutput("after_reset_iter", 64'(res_iterations), 64'h88);
        checkOutput("after_reset_busy", 64'(busy_mask), 64'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
